// File: rtl/chaos_xpander_stream_if.sv
// Chaos-word input handshake and expanded-beat output stream for chaos_xpander_stream.
// The i_data_bit member exists only when CHAOS_XPND_INVERT_EN is defined.
interface chaos_xpander_stream_if #(
    parameter int CHAOS_W = 16,
    parameter int LANE_W  = 32,
    parameter int IDX_W   = 3
);
    logic [CHAOS_W-1:0] i_chaos;
    logic               i_chaos_valid;
    logic               o_chaos_ready;
    logic [LANE_W-1:0]  o_beat;
    logic               o_beat_valid;
    logic               i_beat_ready;
    logic               o_beat_last;
    logic [IDX_W-1:0]   o_beat_idx;
`ifdef CHAOS_XPND_INVERT_EN
    logic               i_data_bit;
`endif

    modport slave (
        input  i_chaos, i_chaos_valid, i_beat_ready,
`ifdef CHAOS_XPND_INVERT_EN
        input  i_data_bit,
`endif
        output o_chaos_ready, o_beat, o_beat_valid, o_beat_last, o_beat_idx
    );

    modport master (
        output i_chaos, i_chaos_valid, i_beat_ready,
`ifdef CHAOS_XPND_INVERT_EN
        output i_data_bit,
`endif
        input  o_chaos_ready, o_beat, o_beat_valid, o_beat_last, o_beat_idx
    );
endinterface

// File: rtl/chaos_xpander_stream.sv
// Streaming chaos expander: latches one chaos word, emits its rotate-shuffled expansion as LANE_W beats.
// Optional macro CHAOS_XPND_INVERT_EN adds a latched data bit that inverts every beat of the word.
module chaos_xpander_stream #(
    parameter int CHAOS_W     = 16,
    parameter int XPND_FACTOR = 16,
    parameter int LANE_W      = 32,
    parameter int ROT_STEP    = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    chaos_xpander_stream_if.slave   bus
);
    localparam int XW    = CHAOS_W * XPND_FACTOR;
    localparam int NB    = XW / LANE_W;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    generate
        if ((XW % LANE_W) != 0) begin : g_lane_chk
            $error("LANE_W must divide CHAOS_W*XPND_FACTOR");
        end
        if ((ROT_STEP < 0) || (ROT_STEP >= CHAOS_W)) begin : g_rot_chk
            $error("ROT_STEP must lie in 0..CHAOS_W-1");
        end
    endgenerate

    // Segment s is the chaos word rotated left by (s*ROT_STEP) mod CHAOS_W; amounts are loop constants.
    function automatic logic [XW-1:0] expand(input logic [CHAOS_W-1:0] c);
        logic [2*CHAOS_W-1:0] dbl;
        logic [XW-1:0]        res;
        int                   rot;
        res = '0;
        for (int s = 0; s < XPND_FACTOR; s++) begin
            rot = (s * ROT_STEP) % CHAOS_W;
            dbl = {c, c} << rot;
            res[s*CHAOS_W +: CHAOS_W] = dbl[2*CHAOS_W-1 -: CHAOS_W];
        end
        return res;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CHAOS_W-1:0] r_chaos, w_chaos_nxt;
    logic               r_inv, w_inv_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_last, w_last_nxt;
    logic [LANE_W-1:0]  r_beat, w_beat_nxt;
    logic [XW-1:0]      w_exp;
    logic               w_xfer, w_ready, w_accept, w_data_bit;

`ifdef CHAOS_XPND_INVERT_EN
    assign w_data_bit = bus.i_data_bit;
`else
    assign w_data_bit = 1'b0;
`endif

    assign w_xfer   = r_valid & bus.i_beat_ready;
    assign w_ready  = (r_state == ST_IDLE) | (w_xfer & r_last);
    assign w_accept = w_ready & bus.i_chaos_valid;

    // Next-state logic; the next beat is precomputed so every stream output comes from a register.
    always_comb begin
        w_state_nxt = r_state;
        w_chaos_nxt = r_chaos;
        w_inv_nxt   = r_inv;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_STREAM;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end
            end
            ST_STREAM: begin
                if (w_xfer && r_last && w_accept) begin
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b1;
                end else if (w_xfer && r_last) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (w_xfer) begin
                    w_idx_nxt   = r_idx + 1'b1;
                end else begin
                    w_idx_nxt   = r_idx;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
        if (w_accept) begin
            w_chaos_nxt = bus.i_chaos;
            w_inv_nxt   = w_data_bit;
        end else begin
            w_chaos_nxt = r_chaos;
            w_inv_nxt   = r_inv;
        end
        w_exp      = expand(w_chaos_nxt);
        w_last_nxt = w_valid_nxt & (w_idx_nxt == LAST_IDX);
        if (w_valid_nxt) begin
            w_beat_nxt = w_exp[int'(w_idx_nxt)*LANE_W +: LANE_W] ^ {LANE_W{w_inv_nxt}};
        end else begin
            w_beat_nxt = '0;
        end
    end

    // State and output registers; a reset drops any partial frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_chaos <= '0;
            r_inv   <= 1'b0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_chaos <= w_chaos_nxt;
            r_inv   <= w_inv_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    assign bus.o_chaos_ready = w_ready;
    assign bus.o_beat        = r_beat;
    assign bus.o_beat_valid  = r_valid;
    assign bus.o_beat_last   = r_last;
    assign bus.o_beat_idx    = r_idx;
endmodule
